// File: rtl/link_tx_ctrl_if.sv
// User-side word handshake into the link transmitter.
// Ports: data_in (8b user word), data_valid (word present), data_ready (word taken this cycle).
// master = user logic supplying words, slave = link_tx_ctrl consuming them.
interface link_tx_ctrl_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;

   modport master (output data_in, output data_valid, input data_ready);
   modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/link_tx_ctrl.sv
// Link transmit controller: OFF/TRAIN/DATA/PRBS sequencing, PRBS7 generator, error injection, counters.
// Latency: D_OUT is registered; an accepted user word appears on D_OUT the cycle after acceptance.
// Backpressure: data_ready is high only in DATA when no state change is taken that cycle; never stalls otherwise.
// Ports: clk160/rstb clock and async active-low reset; tx_enable, train_req, prbs_mode, align_done control;
//        tx_if user word handshake; inject_err, reset_counters; D_OUT, link_state, tx_word_count, err_inj_count.
module link_tx_ctrl #(
   parameter logic [7:0]  TRAIN_WORD = 8'hAA,
   parameter logic [7:0]  IDLE_WORD  = 8'h3C,
   parameter logic [15:0] TRAIN_MIN  = 16'd64
) (
   input  logic                 clk160,
   input  logic                 rstb,
   input  logic                 tx_enable,
   input  logic                 train_req,
   input  logic                 prbs_mode,
   input  logic                 align_done,
   link_tx_ctrl_if.slave        tx_if,
   input  logic                 inject_err,
   input  logic                 reset_counters,
   output logic [7:0]           D_OUT,
   output logic [1:0]           link_state,
   output logic [31:0]          tx_word_count,
   output logic [15:0]          err_inj_count
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_TRAIN = 2'd1,
      ST_DATA  = 2'd2,
      ST_PRBS  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  dout_q, dout_d;
   logic [15:0] train_cnt_q, train_cnt_d, train_cnt_inc;
   logic [6:0]  prbs_q, prbs_d, prbs_s;
   logic [7:0]  prbs_word;
   logic        armed_q, armed_d;
   logic        inj_prev_q;
   logic [1:0]  align_sync_q;
   logic        align_s;
   logic [31:0] tx_cnt_q, tx_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic        data_ready;
   logic        accept;
   logic        inj_edge;
   logic        inj_fire;
   logic [7:0]  word_sel;

   assign align_s = align_sync_q[1];

   // The train counter value includes the word currently on D_OUT, so exit
   // happens after exactly TRAIN_MIN training words when aligned.
   assign train_cnt_inc = (train_cnt_q == 16'hFFFF) ? train_cnt_q : train_cnt_q + 16'd1;

   always_comb begin
      state_d = state_q;
      if (!tx_enable) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF:   state_d = ST_TRAIN;
            ST_TRAIN: if ((train_cnt_inc >= TRAIN_MIN) && align_s && !train_req)
                         state_d = prbs_mode ? ST_PRBS : ST_DATA;
            default:  state_d = train_req ? ST_TRAIN : (prbs_mode ? ST_PRBS : ST_DATA);
         endcase
      end
   end

   assign data_ready       = (state_q == ST_DATA) && (state_d == ST_DATA);
   assign tx_if.data_ready = data_ready;
   assign accept           = tx_if.data_valid && data_ready;

   // Generator restarts from the all-ones seed whenever PRBS is (re)entered.
   always_comb begin
      prbs_s    = (state_q == ST_PRBS) ? prbs_q : 7'h7F;
      prbs_word = 8'h00;
      for (int k = 0; k < 8; k++) begin
         prbs_word[k] = prbs_s[6] ^ prbs_s[5];
         prbs_s       = {prbs_s[5:0], prbs_word[k]};
      end
   end

   // A flag already armed absorbs any further edge until it has been spent on a word.
   assign inj_edge = inject_err && !inj_prev_q && (state_q != ST_OFF);
   assign inj_fire = armed_q && (state_d != ST_OFF);
   assign armed_d  = armed_q ? !inj_fire : inj_edge;

   always_comb begin
      case (state_d)
         ST_OFF:   word_sel = 8'h00;
         ST_TRAIN: word_sel = TRAIN_WORD;
         ST_DATA:  word_sel = accept ? tx_if.data_in : IDLE_WORD;
         default:  word_sel = prbs_word;
      endcase
      dout_d      = word_sel ^ {7'd0, inj_fire};
      prbs_d      = (state_d == ST_PRBS) ? prbs_s : prbs_q;
      train_cnt_d = (state_q == ST_TRAIN) ? train_cnt_inc : 16'd0;

      tx_cnt_d = tx_cnt_q;
      if (reset_counters)
         tx_cnt_d = 32'd0;
      else if ((accept || (state_d == ST_PRBS)) && (tx_cnt_q != 32'hFFFF_FFFF))
         tx_cnt_d = tx_cnt_q + 32'd1;

      err_cnt_d = err_cnt_q;
      if (reset_counters)
         err_cnt_d = 16'd0;
      else if (inj_fire && (err_cnt_q != 16'hFFFF))
         err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk160 or negedge rstb) begin
      if (!rstb) begin
         state_q      <= ST_OFF;
         dout_q       <= 8'h00;
         train_cnt_q  <= 16'd0;
         prbs_q       <= 7'h7F;
         armed_q      <= 1'b0;
         inj_prev_q   <= 1'b0;
         align_sync_q <= 2'b00;
         tx_cnt_q     <= 32'd0;
         err_cnt_q    <= 16'd0;
      end else begin
         state_q      <= state_d;
         dout_q       <= dout_d;
         train_cnt_q  <= train_cnt_d;
         prbs_q       <= prbs_d;
         armed_q      <= armed_d;
         inj_prev_q   <= inject_err;
         align_sync_q <= {align_sync_q[0], align_done};
         tx_cnt_q     <= tx_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign D_OUT         = dout_q;
   assign link_state    = state_q;
   assign tx_word_count = tx_cnt_q;
   assign err_inj_count = err_cnt_q;

endmodule

// File: tb/tb_link_tx_ctrl.sv
// Directed bench for link_tx_ctrl: reset values, training length, DATA vector table,
// PRBS sequence and injection, mode swap, async reset and OFF/TRAIN handling.
// Ports: none (top level); drives the DUT through link_tx_ctrl_if.
module tb_link_tx_ctrl;

   logic        clk160 = 1'b0;
   logic        rstb;
   logic        tx_enable, train_req, prbs_mode, align_done, inject_err, reset_counters;
   logic [7:0]  D_OUT;
   logic [1:0]  link_state;
   logic [31:0] tx_word_count;
   logic [15:0] err_inj_count;

   int n_vec = 0;
   int n_err = 0;

   link_tx_ctrl_if dif();

   link_tx_ctrl #(.TRAIN_WORD(8'hAA), .IDLE_WORD(8'h3C), .TRAIN_MIN(16'd64)) dut (
      .clk160         (clk160),
      .rstb           (rstb),
      .tx_enable      (tx_enable),
      .train_req      (train_req),
      .prbs_mode      (prbs_mode),
      .align_done     (align_done),
      .tx_if          (dif),
      .inject_err     (inject_err),
      .reset_counters (reset_counters),
      .D_OUT          (D_OUT),
      .link_state     (link_state),
      .tx_word_count  (tx_word_count),
      .err_inj_count  (err_inj_count)
   );

   always #5 clk160 = ~clk160;

   typedef struct {
      logic        tx, treq, prbs, vld;
      logic [7:0]  din;
      logic        inj, rstc;
      logic        rdy;
      logic [1:0]  st;
      logic [7:0]  dout;
      logic [31:0] wc;
      logic [15:0] ec;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk160);
      #1;
   endtask

   // Steps until link_state reaches exp_exit, counting TRAIN words seen on D_OUT.
   task automatic train_until_exit(input string tag, input int exp_words, input logic [1:0] exp_exit);
      int words;
      int cyc;
      words = (link_state == 2'd1 && D_OUT == 8'hAA) ? 1 : 0;
      cyc   = 0;
      while (link_state != exp_exit && cyc < 300) begin
         tick();
         cyc++;
         if (link_state == 2'd1 && D_OUT == 8'hAA) words++;
      end
      chk({tag, " exit state"}, 32'(link_state), 32'(exp_exit));
      chk({tag, " train words"}, 32'(words), 32'(exp_words));
   endtask

   function automatic logic [14:0] prbs_next(input logic [6:0] s);
      logic [6:0] t;
      logic [7:0] w;
      t = s;
      w = 8'h00;
      for (int k = 0; k < 8; k++) begin
         w[k] = t[6] ^ t[5];
         t    = {t[5:0], w[k]};
      end
      return {t, w};
   endfunction

   initial begin
      logic [6:0]  ms;
      logic [7:0]  mw;
      logic [7:0]  exp_w;
      logic        bits [0:159];
      int          pm;

      rstb = 1'b1;
      tx_enable = 1'b0; train_req = 1'b0; prbs_mode = 1'b0; align_done = 1'b0;
      inject_err = 1'b0; reset_counters = 1'b0;
      dif.data_in = 8'h00; dif.data_valid = 1'b0;

      // Fields: tx treq prbs vld din inj rstc | rdy st dout wc ec
      vt[0] = '{1'b1,1'b0,1'b0,1'b1,8'h11,1'b0,1'b0, 1'b1,2'd2,8'h11,32'd1,16'd0};
      vt[1] = '{1'b1,1'b0,1'b0,1'b1,8'h22,1'b0,1'b0, 1'b1,2'd2,8'h22,32'd2,16'd0};
      vt[2] = '{1'b1,1'b0,1'b0,1'b0,8'h99,1'b0,1'b0, 1'b1,2'd2,8'h3C,32'd2,16'd0};
      vt[3] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,2'd2,8'h3C,32'd2,16'd0};
      vt[4] = '{1'b1,1'b0,1'b0,1'b1,8'h55,1'b1,1'b0, 1'b1,2'd2,8'h54,32'd3,16'd1};
      vt[5] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,2'd2,8'h3C,32'd3,16'd1};
      vt[6] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,2'd2,8'h3C,32'd3,16'd1};
      vt[7] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,2'd2,8'h3D,32'd3,16'd2};
      vt[8] = '{1'b1,1'b0,1'b0,1'b1,8'h77,1'b0,1'b1, 1'b1,2'd2,8'h77,32'd0,16'd0};
      vt[9] = '{1'b1,1'b1,1'b0,1'b1,8'h88,1'b0,1'b0, 1'b0,2'd1,8'hAA,32'd0,16'd0};

      // Reset values
      #2 rstb = 1'b0;
      #21;
      chk("rst state", 32'(link_state), 32'd0);
      chk("rst dout", 32'(D_OUT), 32'h00);
      chk("rst ready", 32'(dif.data_ready), 32'd0);
      chk("rst wc", tx_word_count, 32'd0);
      chk("rst ec", 32'(err_inj_count), 32'd0);

      // Initial training with align present from the start
      tx_enable = 1'b1;
      align_done = 1'b1;
      @(negedge clk160);
      rstb = 1'b1;
      train_until_exit("train1", 64, 2'd2);
      chk("data entry dout", 32'(D_OUT), 32'h3C);
      chk("data entry ready", 32'(dif.data_ready), 32'd1);
      chk("data entry wc", tx_word_count, 32'd0);

      // DATA vector table
      for (int i = 0; i < 10; i++) begin
         tx_enable      = vt[i].tx;
         train_req      = vt[i].treq;
         prbs_mode      = vt[i].prbs;
         dif.data_valid = vt[i].vld;
         dif.data_in    = vt[i].din;
         inject_err     = vt[i].inj;
         reset_counters = vt[i].rstc;
         #1;
         chk($sformatf("v%0d ready", i), 32'(dif.data_ready), 32'(vt[i].rdy));
         tick();
         chk($sformatf("v%0d state", i), 32'(link_state), 32'(vt[i].st));
         chk($sformatf("v%0d dout", i), 32'(D_OUT), 32'(vt[i].dout));
         chk($sformatf("v%0d wc", i), tx_word_count, vt[i].wc);
         chk($sformatf("v%0d ec", i), 32'(err_inj_count), 32'(vt[i].ec));
      end

      // Retrain, exiting into PRBS
      train_req = 1'b0; prbs_mode = 1'b1; dif.data_valid = 1'b0;
      inject_err = 1'b0; reset_counters = 1'b0;
      train_until_exit("retrain", 64, 2'd3);
      chk("prbs first word", 32'(D_OUT), 32'h40);
      chk("prbs first wc", tx_word_count, 32'd1);
      ms = 7'h7F;
      {ms, mw} = prbs_next(ms);
      for (int b = 0; b < 8; b++) bits[b] = D_OUT[b];

      for (int i = 1; i < 40; i++) begin
         inject_err = (i == 20);
         if (i == 25) align_done = 1'b0;
         {ms, mw} = prbs_next(ms);
         tick();
         exp_w = mw ^ ((i == 21) ? 8'h01 : 8'h00);
         if (i == 1) chk("prbs second word", 32'(D_OUT), 32'h30);
         chk($sformatf("prbs word %0d", i), 32'(D_OUT), 32'(exp_w));
         if (i < 20)
            for (int b = 0; b < 8; b++) bits[i*8 + b] = D_OUT[b];
      end
      inject_err = 1'b0;
      pm = 0;
      for (int b = 0; b < 160 - 127; b++)
         if (bits[b] !== bits[b + 127]) pm++;
      chk("prbs period 127", 32'(pm), 32'd0);
      chk("prbs state held", 32'(link_state), 32'd3);
      chk("prbs wc", tx_word_count, 32'd40);
      chk("prbs ec", 32'(err_inj_count), 32'd1);

      // Mode swap and PRBS reseed on re-entry
      prbs_mode = 1'b0;
      tick();
      chk("swap to data state", 32'(link_state), 32'd2);
      chk("swap to data dout", 32'(D_OUT), 32'h3C);
      chk("swap to data ready", 32'(dif.data_ready), 32'd1);
      prbs_mode = 1'b1;
      tick();
      chk("swap to prbs state", 32'(link_state), 32'd3);
      chk("swap to prbs dout", 32'(D_OUT), 32'h40);
      chk("swap to prbs wc", tx_word_count, 32'd41);

      // Asynchronous reset mid-cycle
      #3 rstb = 1'b0;
      #1;
      chk("async rst state", 32'(link_state), 32'd0);
      chk("async rst dout", 32'(D_OUT), 32'h00);
      chk("async rst ready", 32'(dif.data_ready), 32'd0);
      chk("async rst wc", tx_word_count, 32'd0);
      chk("async rst ec", 32'(err_inj_count), 32'd0);

      // Injection edge in OFF is ignored; no alignment keeps the link in TRAIN
      tx_enable = 1'b0; prbs_mode = 1'b0;
      @(negedge clk160);
      rstb = 1'b1;
      tick();
      inject_err = 1'b1;
      tick();
      inject_err = 1'b0;
      tick();
      tx_enable = 1'b1;
      tick();
      chk("off inj state", 32'(link_state), 32'd1);
      chk("off inj dout", 32'(D_OUT), 32'hAA);
      chk("off inj ec", 32'(err_inj_count), 32'd0);
      for (int i = 0; i < 80; i++) tick();
      chk("no align state", 32'(link_state), 32'd1);
      chk("no align dout", 32'(D_OUT), 32'hAA);
      tx_enable = 1'b0;
      tick();
      chk("train off state", 32'(link_state), 32'd0);
      chk("train off dout", 32'(D_OUT), 32'h00);
      align_done = 1'b1;
      tick();
      tx_enable = 1'b1;
      train_until_exit("train3", 64, 2'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/link_tx_ctrl.md
LINK_TX_CTRL -- requirements
Module: link_tx_ctrl

Interface
REQ-001 Parameters SHALL be: TRAIN_WORD, default 8'hAA, pattern sent during training; IDLE_WORD, default 8'h3C, filler word; TRAIN_MIN, default 64, minimum training words before exit (16-bit).
REQ-002 Ports SHALL be:
- clk160  in  1  sole clock; all logic on rising edge
- rstb  in  1  reset, asynchronous assert, active-low
- tx_enable  in  1  link enable (level)
- train_req  in  1  request retraining (level)
- prbs_mode  in  1  1 = PRBS7 payload, 0 = user data
- align_done  in  1  far-end receiver aligned (asynchronous level)
- data_in  in  8  user word
- data_valid  in  1  data_in valid
- data_ready  out  1  word accepted this cycle when data_valid && data_ready
- inject_err  in  1  error-injection request
- reset_counters  in  1  synchronous counter clear
- D_OUT  out  8  registered parallel word to serializer, bit 0 sent first
- link_state  out  2  0 OFF, 1 TRAIN, 2 DATA, 3 PRBS
- tx_word_count  out  32  payload words sent, saturating
- err_inj_count  out  16  injected errors, saturating

Function
REQ-003 align_done SHALL pass through a 2-flop synchronizer (align_s); only align_s is used.
REQ-004 State OFF: D_OUT = 8'h00; data_ready = 0; train counter cleared; exit to TRAIN on the cycle after tx_enable is sampled 1.
REQ-005 From any state, tx_enable sampled 0 SHALL move to OFF the next cycle (highest priority).
REQ-006 State TRAIN: D_OUT = TRAIN_WORD every cycle; train counter increments per cycle, saturating at 16'hFFFF.
REQ-007 TRAIN exit SHALL require train counter >= TRAIN_MIN && align_s && !train_req; target is PRBS if prbs_mode else DATA.
REQ-008 From DATA or PRBS, train_req sampled 1 SHALL enter TRAIN next cycle with train counter cleared (priority below REQ-005).
REQ-009 DATA and PRBS SHALL swap on a prbs_mode change, taking effect the next cycle.
REQ-010 data_ready SHALL be 1 only when link_state == DATA and no transition out of DATA is taken in that cycle.
REQ-011 In DATA: on acceptance D_OUT = data_in on the following cycle (1-cycle latency); otherwise D_OUT = IDLE_WORD.
REQ-012 PRBS7 (x^7 + x^6 + 1): 7-bit state s reloaded to 7'h7F on every entry to PRBS; per cycle, for k = 0..7 in order, bit k = s[6] ^ s[5], then s = {s[5:0], bit k}; D_OUT = the 8 bits generated.
REQ-013 First PRBS word after entry from seed 7'h7F SHALL be 8'h00... no: it SHALL be computed per REQ-012 (bits 0..7 = 0,0,0,0,0,0,1,0 → 8'h40).
REQ-014 inject_err rising edge (registered previous value) SHALL arm a flag; the next D_OUT word in TRAIN, DATA or PRBS is sent with bit 0 inverted and the flag cleared; edges in OFF are ignored and do not arm.
REQ-015 An edge arriving while the flag is already armed SHALL not be counted twice; err_inj_count increments once per inverted word, saturating at 16'hFFFF.
REQ-016 Injection SHALL NOT alter PRBS state s; only the output bit is inverted.
REQ-017 tx_word_count SHALL increment per accepted DATA word and per PRBS word, saturating at 32'hFFFFFFFF; TRAIN, IDLE_WORD and OFF cycles do not count.
REQ-018 reset_counters = 1 SHALL zero tx_word_count and err_inj_count next cycle, taking priority over simultaneous increments; link state unaffected.
REQ-019 align_s falling during DATA/PRBS SHALL NOT force retraining; only train_req or tx_enable do.

Reset
REQ-020 rstb low SHALL asynchronously force: link_state OFF, D_OUT 8'h00, data_ready 0, both counters 0, train counter 0, s = 7'h7F, injection flag 0, synchronizer and edge register 0.
REQ-021 Reset mid-word SHALL drop any accepted-but-unsent word; after release the block re-enters TRAIN per REQ-004.

Verification
REQ-022 tx_enable=1, align_done=1 from start, TRAIN_MIN=64 -> 64 words of 8'hAA minimum, then DATA; data_ready asserts first DATA cycle.
REQ-023 In DATA, data_valid=1 with 8'h11, 8'h22 then valid=0 -> D_OUT 8'h11, 8'h22, 8'h3C; tx_word_count = 2.
REQ-024 prbs_mode=1 after training -> first word 8'h40, sequence period 127 bits; loopback into the companion receiver shows zero errors.
REQ-025 inject_err pulse in PRBS -> exactly one word with bit 0 flipped, err_inj_count = 1, following words match golden PRBS.
REQ-026 train_req pulse in DATA -> TRAIN next cycle, data_ready 0, ≥64 training words before DATA resumes; tx_enable=0 in TRAIN -> OFF, D_OUT 8'h00.
REQ-027 rstb asserted during PRBS with counters nonzero -> all outputs at REQ-020 values immediately, without waiting for a clock edge.
